// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and default
// bit timing. Used by both the transmitter and the receiver.
package uart_pkg;

    // Frame phases. The encoding is fixed so that transmitter and receiver
    // state can be compared directly when debugging a loopback.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        START   = 2'b01,
        DATABIT = 2'b10,
        STOP    = 2'b11
    } uart_state_e;

    // Payload bits per frame.
    localparam int DATA_BITS = 8;

    // 25 MHz system clock divided down to 115200 bps.
    localparam int DEFAULT_CLOCKS_PER_BIT = 217;

    // Width of a counter that must hold the values 0..clocks_per_bit-1.
    // A one-bit counter is the smallest that makes sense.
    function automatic int bit_count_width(input int clocks_per_bit);
        if (clocks_per_bit <= 2) begin
            return 1;
        end
        return $clog2(clocks_per_bit);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clock cycles inside one serial bit and flags the
// last cycle of the bit. Shared between the UART transmitter and receiver.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT,
    parameter int COUNT_WIDTH    = bit_count_width(CLOCKS_PER_BIT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   enable,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   bit_end
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(CLOCKS_PER_BIT - 1);

    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise advance and wrap at the end of the bit
    // so back-to-back bits need no extra clear cycle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            if (count_q == LAST_COUNT) begin
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign bit_end = enable && !clear && (count_q == LAST_COUNT);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit, no
// parity. Bytes arrive over a valid/ready handshake into a one-deep holding
// register so a new frame can follow the previous stop bit with no idle gap.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = DEFAULT_CLOCKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       dataserial,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = bit_count_width(CLOCKS_PER_BIT);

    // tx_done is registered, so it is set one count before the final cycle
    // of the stop bit in order to be high exactly during that final cycle.
    localparam logic [CW-1:0] DONE_SET_COUNT = CW'(CLOCKS_PER_BIT - 2);
    localparam logic [2:0]    LAST_BIT_INDEX = 3'(DATA_BITS - 1);

    uart_state_e state_q;
    uart_state_e state_d;

    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [2:0] bit_index_q;
    logic [2:0] bit_index_d;

    logic [7:0] hold_data_q;
    logic [7:0] hold_data_d;
    logic       hold_full_q;
    logic       hold_full_d;

    logic       dataserial_q;
    logic       dataserial_d;
    logic       tx_busy_q;
    logic       tx_busy_d;
    logic       tx_done_q;
    logic       tx_done_d;

    logic [CW-1:0] clk_count;
    logic          bit_end;
    logic          timer_clear;
    logic          timer_enable;
    logic          load;
    logic          accept;

    // The bit timer sits at zero while idle so every frame starts with a
    // full-length start bit; during a frame it free-runs and wraps per bit.
    always_comb begin
        timer_clear  = (state_q == IDLE);
        timer_enable = (state_q != IDLE);
    end

    uart_bit_timer #(
        .CLOCKS_PER_BIT (CLOCKS_PER_BIT),
        .COUNT_WIDTH    (CW)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .count   (clk_count),
        .bit_end (bit_end)
    );

    // Frame sequencing: walk START -> 8 x DATABIT -> STOP, loading the shift
    // register from the holding register whenever a frame begins. From STOP
    // the next frame starts directly if a byte is already waiting.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_index_d = bit_index_q;
        load        = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    shift_d = hold_data_q;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d     = DATABIT;
                    bit_index_d = 3'd0;
                end
            end
            DATABIT: begin
                if (bit_end) begin
                    if (bit_index_q == LAST_BIT_INDEX) begin
                        state_d = STOP;
                    end else begin
                        bit_index_d = bit_index_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (hold_full_q) begin
                        load    = 1'b1;
                        shift_d = hold_data_q;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Holding register: a load empties it and an accept fills it; when both
    // fall on one edge the accept is applied last so the new byte is kept.
    always_comb begin
        accept      = tx_valid && !hold_full_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        if (load) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_data;
        end
    end

    // Registered outputs are computed from the next state so the serial line
    // changes on the same edge as the state it belongs to.
    always_comb begin
        dataserial_d = 1'b1;
        case (state_d)
            IDLE:    dataserial_d = 1'b1;
            START:   dataserial_d = 1'b0;
            DATABIT: dataserial_d = shift_d[bit_index_d];
            STOP:    dataserial_d = 1'b1;
            default: dataserial_d = 1'b1;
        endcase
        tx_busy_d = (state_d != IDLE);
        tx_done_d = (state_q == STOP) && (clk_count == DONE_SET_COUNT);
    end

    // State, datapath and output registers; reset aborts any frame in flight
    // and drops a byte waiting in the holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= 8'h00;
            bit_index_q  <= 3'd0;
            hold_data_q  <= 8'h00;
            hold_full_q  <= 1'b0;
            dataserial_q <= 1'b1;
            tx_busy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_index_q  <= bit_index_d;
            hold_data_q  <= hold_data_d;
            hold_full_q  <= hold_full_d;
            dataserial_q <= dataserial_d;
            tx_busy_q    <= tx_busy_d;
            tx_done_q    <= tx_done_d;
        end
    end

    assign tx_ready   = !hold_full_q;
    assign dataserial = dataserial_q;
    assign tx_busy    = tx_busy_q;
    assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter. A fast instance (4 clocks per bit) is
// checked cycle by cycle by a frame monitor against a scoreboard queue of
// accepted bytes; a second instance at 217 clocks per bit is decoded by a
// mid-bit sampling receiver model as a loopback check.
module tb_uart_transmitter;

    localparam int CPB      = 4;
    localparam int FRAME    = 10 * CPB;
    localparam int SLOW_CPB = 217;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready;
    logic       dataserial;
    logic       tx_busy;
    logic       tx_done;

    logic       s_valid = 1'b0;
    logic [7:0] s_data  = 8'h00;
    logic       s_ready;
    logic       s_serial;
    logic       s_busy;
    logic       s_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int frames = 0;
    int s_done_count = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_s[$];
    int         start_q[$];

    uart_transmitter #(.CLOCKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .dataserial (dataserial),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    uart_transmitter #(.CLOCKS_PER_BIT(SLOW_CPB)) dut_slow (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (s_valid),
        .tx_data    (s_data),
        .tx_ready   (s_ready),
        .dataserial (s_serial),
        .tx_busy    (s_busy),
        .tx_done    (s_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // One comparison: counts it, and reports it when actual differs.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Offer one byte to the fast instance, wait (bounded) for tx_ready and
    // record the byte as expected once the handshake edge is reached.
    // Called away from the clock edge; returns 1 time unit after acceptance.
    task automatic applyStimulus(input logic [7:0] b);
        int waited;
        waited   = 0;
        tx_valid = 1'b1;
        tx_data  = b;
        while (tx_ready !== 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (tx_ready !== 1'b1) begin
            checkOutput("accept_timeout", 32'(tx_ready), 32'd1);
            tx_valid = 1'b0;
        end else begin
            exp_q.push_back(b);
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            tx_data  = ~b;
        end
    endtask

    // Wait (bounded) until every accepted byte has left the line.
    task automatic waitDrain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy !== 1'b0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checkOutput("drain_pending_bytes", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic sendSlow(input logic [7:0] b);
        int waited;
        waited = 0;
        while (s_ready !== 1'b1 && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (s_ready !== 1'b1) begin
            checkOutput("slow_accept_timeout", 32'(s_ready), 32'd1);
        end else begin
            exp_s.push_back(b);
            s_valid = 1'b1;
            s_data  = b;
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            s_data  = 8'h00;
        end
    endtask

    // Fast-instance frame monitor: every cycle of a frame is checked for
    // the right line level, tx_busy high, and tx_done only on the last cycle.
    logic [7:0] mon_rx;
    logic       mon_shape_ok;
    logic       mon_done_ok;
    logic       mon_busy_ok;
    logic       mon_aborted;
    int         mon_first;
    int         mon_bit;
    logic [7:0] mon_exp;

    initial begin : fast_monitor
        forever begin
            @(negedge clk);
            if (!rst && dataserial === 1'b0) begin
                mon_first    = cyc;
                mon_rx       = 8'h00;
                mon_shape_ok = 1'b1;
                mon_done_ok  = 1'b1;
                mon_busy_ok  = 1'b1;
                mon_aborted  = 1'b0;
                for (int k = 0; k < FRAME; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst) begin
                        mon_aborted = 1'b1;
                        break;
                    end
                    mon_bit = k / CPB;
                    if (mon_bit == 0) begin
                        if (dataserial !== 1'b0) mon_shape_ok = 1'b0;
                    end else if (mon_bit == 9) begin
                        if (dataserial !== 1'b1) mon_shape_ok = 1'b0;
                    end else if ((k % CPB) == 0) begin
                        mon_rx[mon_bit-1] = dataserial;
                    end else if (dataserial !== mon_rx[mon_bit-1]) begin
                        mon_shape_ok = 1'b0;
                    end
                    if (tx_done !== (k == FRAME - 1)) mon_done_ok = 1'b0;
                    if (tx_busy !== 1'b1) mon_busy_ok = 1'b0;
                end
                if (!mon_aborted) begin
                    frames++;
                    start_q.push_back(mon_first);
                    checkOutput("frame_shape", 32'(mon_shape_ok), 32'd1);
                    checkOutput("frame_done_pulse", 32'(mon_done_ok), 32'd1);
                    checkOutput("frame_busy", 32'(mon_busy_ok), 32'd1);
                    checkOutput("frame_was_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        mon_exp = exp_q.pop_front();
                        checkOutput("frame_data", 32'(mon_rx), 32'(mon_exp));
                    end
                end else begin
                    while (rst) @(negedge clk);
                end
            end else if (!rst && tx_done === 1'b1) begin
                checkOutput("done_outside_frame", 32'(tx_done), 32'd0);
            end
        end
    end

    // Slow-instance receiver model: mid-bit sampling as a real UART receiver.
    logic [9:0] s_bits;
    logic [7:0] s_exp;

    initial begin : slow_monitor
        forever begin
            @(negedge clk);
            if (!rst && s_serial === 1'b0) begin
                repeat (SLOW_CPB / 2) @(negedge clk);
                s_bits[0] = s_serial;
                for (int i = 1; i < 10; i++) begin
                    repeat (SLOW_CPB) @(negedge clk);
                    s_bits[i] = s_serial;
                end
                checkOutput("loop_framing", 32'({s_bits[9], s_bits[0]}), 32'h2);
                checkOutput("loop_was_expected", 32'(exp_s.size() != 0), 32'd1);
                if (exp_s.size() != 0) begin
                    s_exp = exp_s.pop_front();
                    checkOutput("loop_byte", 32'(s_bits[8:1]), 32'(s_exp));
                end
            end
        end
    end

    always @(negedge clk) if (s_done === 1'b1) s_done_count++;

    int line_bad;
    int frames_before;
    int n;

    initial begin : main
        // Power-on reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_dataserial", 32'(dataserial), 32'd1);
        checkOutput("reset_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("reset_tx_busy", 32'(tx_busy), 32'd0);
        checkOutput("reset_tx_done", 32'(tx_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte A5: line 0,1,0,1,0,0,1,0,1,1 per bit, done on cycle 40.
        $display("[TB] single byte 8'hA5");
        start_q.delete();
        applyStimulus(8'hA5);
        waitDrain(200);
        checkOutput("single_frame_count", 32'(start_q.size()), 32'd1);

        // Back-to-back with valid held: hold full drops ready, no idle gap.
        $display("[TB] back-to-back 8'h00, 8'hFF");
        start_q.delete();
        applyStimulus(8'h00);
        checkOutput("ready_drops_when_full", 32'(tx_ready), 32'd0);
        applyStimulus(8'hFF);
        waitDrain(300);
        checkOutput("b2b_frame_count", 32'(start_q.size()), 32'd2);
        if (start_q.size() == 2)
            checkOutput("b2b_gap", 32'(start_q[1] - start_q[0]), 32'(FRAME));

        // Backpressure: three bytes offered continuously.
        $display("[TB] backpressure 8'h01, 8'h02, 8'h03");
        start_q.delete();
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        waitDrain(400);
        checkOutput("bp_frame_count", 32'(start_q.size()), 32'd3);

        // Third byte accepted right after the STOP->START load of the second.
        $display("[TB] accept around stop-to-start load");
        start_q.delete();
        applyStimulus(8'h81);
        applyStimulus(8'h42);
        applyStimulus(8'h99);
        waitDrain(400);
        checkOutput("load_frame_count", 32'(start_q.size()), 32'd3);
        if (start_q.size() == 3)
            checkOutput("load_third_gap", 32'(start_q[2] - start_q[1]), 32'(FRAME));

        // Reset mid-frame with a second byte waiting: both must vanish.
        $display("[TB] reset mid-frame");
        applyStimulus(8'h5A);
        applyStimulus(8'hC3);
        repeat (15) @(negedge clk);
        frames_before = frames;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        checkOutput("midreset_dataserial", 32'(dataserial), 32'd1);
        checkOutput("midreset_tx_ready", 32'(tx_ready), 32'd1);
        checkOutput("midreset_tx_busy", 32'(tx_busy), 32'd0);
        checkOutput("midreset_tx_done", 32'(tx_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        line_bad = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (dataserial !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) line_bad++;
        end
        checkOutput("idle_after_reset", 32'(line_bad), 32'd0);
        checkOutput("frames_after_reset", 32'(frames - frames_before), 32'd0);

        // Recovery after reset.
        applyStimulus(8'h3C);
        waitDrain(200);

        // Loopback at full bit timing.
        $display("[TB] loopback at 217 clocks per bit");
        sendSlow(8'h3C);
        sendSlow(8'hC3);
        n = 0;
        while ((exp_s.size() != 0 || s_busy !== 1'b0) && n < 8000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checkOutput("loop_pending_bytes", 32'(exp_s.size()), 32'd0);
        checkOutput("loop_done_pulses", 32'(s_done_count), 32'd2);

        checkOutput("fast_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
